// File: rtl/card_dealer.sv
// card_dealer: deals cards one at a time from a 52-card deck.
//   Each draw first tries random ranks taken from a free-running LFSR. After
//   RETRY_LIMIT misses it falls back to a linear scan of the ranks, so every
//   draw ends within a bounded number of cycles.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   shuffle      restore the full deck and abort any draw in progress
//   draw_req     request one card (sampled every cycle)
//   card_value   blackjack value of the last dealt card (2..11)
//   card_rank    rank of the last dealt card (0=A, 1..9=2..10, 10=J, 11=Q, 12=K)
//   card_ready   high while the last dealt card is valid
//   busy         high while a draw is in progress
//   cards_left   cards remaining in the deck (0..52)
//   deck_empty   high when cards_left == 0
module card_dealer #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          RETRY_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic       draw_req,
  output logic [3:0] card_value,
  output logic [3:0] card_rank,
  output logic       card_ready,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       deck_empty
);

  localparam int TW = (RETRY_LIMIT < 2) ? 1 : $clog2(RETRY_LIMIT);
  localparam logic [TW-1:0] TRY_LAST = TW'(RETRY_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, DRAW, SCAN, DONE} state_t;

  state_t        state_reg;
  logic [15:0]   lfsr_reg;
  logic [15:0]   lfsr_next;
  logic [TW-1:0] try_reg;
  logic [3:0]    ptr_reg;
  logic [2:0]    cnt_reg [13];
  logic [12:0]   nz;

  logic [3:0]    cand;
  logic [3:0]    cand_mod;
  logic [3:0]    sel;
  logic          sel_valid;
  logic          hit;

  // Galois LFSR, shifts right; taps folded in when the output bit is 1.
  assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);

  genvar gi;
  generate
    for (gi = 0; gi < 13; gi++) begin : g_nz
      assign nz[gi] = (cnt_reg[gi] != 3'd0);
    end
  endgenerate

  // A DRAW candidate of 13..15 never hits; it is only used to seed the scan.
  assign cand      = lfsr_reg[3:0];
  assign cand_mod  = (cand >= 4'd13) ? (cand - 4'd13) : cand;
  assign sel_valid = (state_reg == SCAN) || (cand <= 4'd12);
  assign sel       = (state_reg == SCAN) ? ptr_reg : (sel_valid ? cand : 4'd0);
  assign hit       = ((state_reg == DRAW) || (state_reg == SCAN)) && sel_valid && nz[sel];

  assign busy       = (state_reg == DRAW) || (state_reg == SCAN);
  assign deck_empty = (cards_left == 6'd0);

  function automatic logic [3:0] value_of(input logic [3:0] rank);
    if (rank == 4'd0)       return 4'd11;
    else if (rank <= 4'd9)  return rank + 4'd1;
    else                    return 4'd10;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      lfsr_reg   <= LFSR_SEED;
      try_reg    <= '0;
      ptr_reg    <= 4'd0;
      for (int i = 0; i < 13; i++) cnt_reg[i] <= 3'd4;
      cards_left <= 6'd52;
      card_value <= 4'd0;
      card_rank  <= 4'd0;
      card_ready <= 1'b0;
    end else begin
      lfsr_reg <= lfsr_next;
      if (shuffle) begin
        for (int i = 0; i < 13; i++) cnt_reg[i] <= 3'd4;
        cards_left <= 6'd52;
        card_ready <= 1'b0;
        state_reg  <= IDLE;
      end else begin
        case (state_reg)
          IDLE, DONE: begin
            if (draw_req && !deck_empty) begin
              state_reg  <= DRAW;
              card_ready <= 1'b0;
              try_reg    <= '0;
            end
          end
          DRAW, SCAN: begin
            if (hit) begin
              cnt_reg[sel] <= cnt_reg[sel] - 3'd1;
              cards_left   <= cards_left - 6'd1;
              card_rank    <= sel;
              card_value   <= value_of(sel);
              card_ready   <= 1'b1;
              state_reg    <= DONE;
            end else if (state_reg == DRAW) begin
              try_reg <= try_reg + 1'b1;
              if (try_reg == TRY_LAST) begin
                state_reg <= SCAN;
                ptr_reg   <= cand_mod;
              end
            end else begin
              ptr_reg <= (ptr_reg == 4'd12) ? 4'd0 : ptr_reg + 4'd1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Testbench for card_dealer: table of deck operations plus hand-written
// sequences for full-deck drain, shuffle while busy, reset mid-draw and
// reproducibility of the dealt sequence after reset.
module tb_card_dealer;
  localparam int RL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       shuffle;
  logic       draw_req;
  logic [3:0] card_value;
  logic [3:0] card_rank;
  logic       card_ready;
  logic       busy;
  logic [5:0] cards_left;
  logic       deck_empty;

  int total = 0;
  int bad   = 0;

  card_dealer #(.LFSR_SEED(16'hACE1), .RETRY_LIMIT(RL)) dut (
    .clk(clk), .rst(rst), .shuffle(shuffle), .draw_req(draw_req),
    .card_value(card_value), .card_rank(card_rank), .card_ready(card_ready),
    .busy(busy), .cards_left(cards_left), .deck_empty(deck_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit shuf;
    bit drw;
    int exp_left;
    bit exp_ready;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  function automatic int val_of(input int r);
    if (r == 0) return 11;
    else if (r <= 9) return r + 1;
    else return 10;
  endfunction

  // One accepted draw: pulse draw_req, wait for card_ready with a bound.
  task automatic draw_one(input string tag, input int exp_left, output int rank);
    int lat;
    @(negedge clk); draw_req = 1'b1;
    @(negedge clk); draw_req = 1'b0;
    check({tag, "_busy_after_req"}, int'(busy), 1);
    lat = 0;
    while (!card_ready && lat < RL + 14) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_ready"}, int'(card_ready), 1);
    check({tag, "_left"}, int'(cards_left), exp_left);
    check({tag, "_value_map"}, int'(card_value), val_of(int'(card_rank)));
    rank = int'(card_rank);
    $display("txn %s rank=%0d value=%0d latency=%0d left=%0d", tag, rank,
             int'(card_value), lat, int'(cards_left));
  endtask

  task automatic pulse(input bit s, input bit d);
    @(negedge clk); shuffle = s; draw_req = d;
    @(negedge clk); shuffle = 1'b0; draw_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[7];
    int   ra[5];
    int   rb[5];
    int   tally[13];
    int   r;
    int   vsum;
    int   exp_last;
    bit   saw_ready;

    tbl[0] = '{1'b1, 1'b0, 52, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 51, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 50, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 52, 1'b0};   // shuffle wins over draw_req in DONE
    tbl[4] = '{1'b0, 1'b1, 51, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 51, 1'b1};   // idle cycle: card stays valid
    tbl[6] = '{1'b1, 1'b0, 52, 1'b0};

    rst = 1'b1; shuffle = 1'b0; draw_req = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(card_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_left", int'(cards_left), 52);
    check("rst_value", int'(card_value), 0);
    check("rst_rank", int'(card_rank), 0);
    check("rst_empty", int'(deck_empty), 0);
    @(negedge clk); rst = 1'b0;

    // Sequence A right after reset release.
    for (int i = 0; i < 5; i++) draw_one($sformatf("seqA%0d", i), 51 - i, ra[i]);

    // Reset in the middle of a draw.
    @(negedge clk); draw_req = 1'b1;
    @(negedge clk); draw_req = 1'b0;
    check("middraw_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("middraw_rst_busy", int'(busy), 0);
    check("middraw_rst_ready", int'(card_ready), 0);
    check("middraw_rst_left", int'(cards_left), 52);
    check("middraw_rst_value", int'(card_value), 0);
    check("middraw_rst_rank", int'(card_rank), 0);
    @(negedge clk); rst = 1'b0;

    // Sequence B with identical timing must repeat sequence A.
    for (int i = 0; i < 5; i++) begin
      draw_one($sformatf("seqB%0d", i), 51 - i, rb[i]);
      check($sformatf("repeat_rank%0d", i), rb[i], ra[i]);
    end

    // Table of deck operations.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].drw && !tbl[i].shuf) begin
        draw_one($sformatf("tbl%0d", i), tbl[i].exp_left, r);
      end else if (tbl[i].shuf) begin
        pulse(tbl[i].shuf, tbl[i].drw);
        check($sformatf("tbl%0d_busy", i), int'(busy), 0);
        @(negedge clk);
        check($sformatf("tbl%0d_no_draw", i), int'(busy), 0);
      end else begin
        @(negedge clk);
      end
      check($sformatf("tbl%0d_left", i), int'(cards_left), tbl[i].exp_left);
      check($sformatf("tbl%0d_ready", i), int'(card_ready), int'(tbl[i].exp_ready));
      $display("txn tbl%0d shuf=%0d drw=%0d left=%0d ready=%0d", i, tbl[i].shuf,
               tbl[i].drw, int'(cards_left), int'(card_ready));
    end

    // Drain the whole deck.
    for (int k = 0; k < 13; k++) tally[k] = 0;
    vsum = 0;
    for (int i = 0; i < 52; i++) begin
      exp_last = -1;
      if (i == 51) begin
        for (int k = 0; k < 13; k++) if (tally[k] == 3) exp_last = k;
      end
      draw_one($sformatf("deal%0d", i), 51 - i, r);
      if (r >= 0 && r <= 12) tally[r]++;
      vsum += int'(card_value);
      if (i == 51) check("last_card_rank", r, exp_last);
    end
    for (int k = 0; k < 13; k++) check($sformatf("tally_rank%0d", k), tally[k], 4);
    check("value_sum", vsum, 380);
    check("drained_left", int'(cards_left), 0);
    check("drained_empty", int'(deck_empty), 1);

    // A 53rd request must be ignored.
    pulse(1'b0, 1'b1);
    saw_ready = 1'b0;
    for (int c = 0; c < RL + 16; c++) begin
      if (busy || !card_ready) saw_ready = 1'b1;
      @(negedge clk);
    end
    check("empty_req_ignored", int'(saw_ready), 0);
    $display("txn draw53 busy=%0d left=%0d", int'(busy), int'(cards_left));

    // Shuffle while a draw is in progress.
    pulse(1'b1, 1'b0);
    check("reshuffle_left", int'(cards_left), 52);
    @(negedge clk); draw_req = 1'b1;
    @(negedge clk); draw_req = 1'b0; shuffle = 1'b1;
    check("busy_before_abort", int'(busy), 1);
    @(negedge clk); shuffle = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_left", int'(cards_left), 52);
    check("abort_ready", int'(card_ready), 0);
    saw_ready = 1'b0;
    for (int c = 0; c < RL + 16; c++) begin
      if (card_ready || busy) saw_ready = 1'b1;
      @(negedge clk);
    end
    check("abort_no_card", int'(saw_ready), 0);
    $display("txn abort left=%0d ready=%0d", int'(cards_left), int'(card_ready));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 The block SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero reset value of the draw LFSR.
REQ-002 The block SHALL have parameter RETRY_LIMIT, default 8, number of random tries before deterministic scan.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port shuffle  input  1  restore full 52-card deck, abort any draw.
REQ-006 The block SHALL have port draw_req  input  1  request one card (level sampled per cycle).
REQ-007 The block SHALL have port card_value  output  4  blackjack value of last dealt card (2..11).
REQ-008 The block SHALL have port card_rank  output  4  rank of last dealt card, 0=A, 1..9=2..10, 10=J, 11=Q, 12=K.
REQ-009 The block SHALL have port card_ready  output  1  high while last dealt card is valid.
REQ-010 The block SHALL have port busy  output  1  high while a draw is in progress.
REQ-011 The block SHALL have port cards_left  output  6  cards remaining in deck (0..52).
REQ-012 The block SHALL have port deck_empty  output  1  high when cards_left == 0.

Function
REQ-013 The block SHALL keep 13 rank counters, 3 bits each, each 0..4; cards_left SHALL equal their sum.
REQ-014 The block SHALL run a 16-bit Galois LFSR (mask 16'hB400) that advances every cycle, unaffected by shuffle.
REQ-015 The FSM SHALL have states IDLE, DRAW, SCAN, DONE; busy = (DRAW or SCAN).
REQ-016 In IDLE or DONE, draw_req=1 with deck_empty=0 SHALL go to DRAW next edge, clear card_ready, and zero the try counter.
REQ-017 draw_req in DRAW or SCAN, or while deck_empty=1, SHALL be ignored; no card_ready rise.
REQ-018 In DRAW the candidate SHALL be lfsr[3:0]; it SHALL hit if candidate <= 12 and its counter is nonzero.
REQ-019 On a DRAW miss the try counter SHALL increment; at RETRY_LIMIT misses the FSM SHALL go to SCAN with pointer = candidate mod 13.
REQ-020 SCAN SHALL test one rank per cycle, pointer incrementing with wrap 12->0, and hit on the first nonzero counter; it SHALL take at most 13 cycles.
REQ-021 On a hit (DRAW or SCAN) at one edge, the block SHALL decrement that rank counter and cards_left, register card_rank and card_value, set card_ready=1, and go to DONE.
REQ-022 Value mapping: rank 0 -> 11; ranks 1..9 -> rank+1; ranks 10..12 -> 10.
REQ-023 Minimum latency: draw_req accepted at edge k SHALL give card_ready high after edge k+1.
REQ-024 card_ready SHALL stay high in DONE until the next accepted draw_req or shuffle, so each card gives exactly one rising edge.
REQ-025 card_value and card_rank SHALL hold their values until the next hit, shuffle or reset.
REQ-026 Shuffle SHALL take priority over draw_req in the same cycle.
REQ-027 Shuffle in any state SHALL, at the next edge, set all counters to 4, set cards_left=52, set card_ready=0, go to IDLE, and leave card_value and card_rank unchanged.
REQ-028 The 52nd draw SHALL complete normally; deck_empty SHALL then be 1 and later draw_req SHALL be ignored until shuffle.

Reset
REQ-029 While rst=1, the block SHALL force: FSM=IDLE, lfsr=LFSR_SEED, all counters=4, cards_left=52, card_value=0, card_rank=0, card_ready=0, busy=0, deck_empty=0.
REQ-030 rst asserted mid-draw SHALL abort the draw immediately, with no counter decrement.

Verification
REQ-031 Reset, then draw_req for 1 cycle -> busy=1 next cycle; card_ready rises 2..(RETRY_LIMIT+14) cycles later; cards_left=51; card_value consistent with card_rank.
REQ-032 52 draws, each waiting for card_ready -> each rank drawn exactly 4 times, value sum = 380, cards_left=0, deck_empty=1; 53rd draw_req -> no card_ready, busy stays 0.
REQ-033 Shuffle and draw_req in the same cycle while in DONE -> IDLE, card_ready=0, cards_left=52, no draw started.
REQ-034 Shuffle asserted while busy=1 -> next cycle busy=0, cards_left=52, no card_ready rise.
REQ-035 Deck drained to a single remaining rank (e.g. only K, counter 4) -> next draw produces card_rank=12, card_value=10 via DRAW or SCAN within RETRY_LIMIT+14 cycles.
REQ-036 rst pulsed during DRAW -> outputs at their reset values immediately; LFSR re-seeded; identical stimulus after reset reproduces the identical card sequence.
